mc_ctrl: RTL and testbench

- Multi-cycle control unit for the MIPS core; sits directly upstream of the datapath and drives every datapath write enable and mux select.
- Sequences each instruction through FETCH/DCD/EXE/MEM/WB from the IR opcode/funct and the ALU zero flag.
- Replaces single-cycle combinational control, so the datapath can share one ALU and run with a slow instruction memory.

---
 rtl/mc_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control FSM (FETCH/DCD/EXE/MEM/WB) driving
//               datapath write enables and mux selects. Optional performance
//               counters are enabled with `define MC_CTRL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int unsigned IM_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic [1:0] npc_sel,
    output logic       ir_wr,
    output logic       gpr_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic [1:0] alu_op,
    output logic       dm_wr,
    output logic       illegal,
    output logic [2:0] state
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [2:0] c_FETCH = 3'd0;
    localparam logic [2:0] c_DCD   = 3'd1;
    localparam logic [2:0] c_EXE   = 3'd2;
    localparam logic [2:0] c_MEM   = 3'd3;
    localparam logic [2:0] c_WB    = 3'd4;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;

    localparam logic [3:0] c_IM_LAT = IM_LAT[3:0];

    logic [2:0] r_state;
    logic [3:0] r_cnt;

    logic w_is_addu, w_is_subu, w_is_rtype, w_is_ori, w_is_lui;
    logic w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_jal, w_legal;
    logic w_fetch_done;
    logic [1:0] w_cls_alu_op, w_cls_ext_op;
    logic w_cls_alu_src;

    assign w_is_addu  = (op == c_OP_RTYPE) && (funct == c_FN_ADDU);
    assign w_is_subu  = (op == c_OP_RTYPE) && (funct == c_FN_SUBU);
    assign w_is_rtype = w_is_addu || w_is_subu;
    assign w_is_ori   = (op == c_OP_ORI);
    assign w_is_lui   = (op == c_OP_LUI);
    assign w_is_lw    = (op == c_OP_LW);
    assign w_is_sw    = (op == c_OP_SW);
    assign w_is_beq   = (op == c_OP_BEQ);
    assign w_is_j     = (op == c_OP_J);
    assign w_is_jal   = (op == c_OP_JAL);
    assign w_legal    = w_is_rtype || w_is_ori || w_is_lui || w_is_lw || w_is_sw ||
                        w_is_beq || w_is_j || w_is_jal;

    assign w_fetch_done = (r_cnt == c_IM_LAT);
    assign state        = r_state;

    // ALU configuration is a property of the instruction class, held outside FETCH
    always_comb begin
        w_cls_alu_op  = 2'b00;
        w_cls_alu_src = 1'b0;
        w_cls_ext_op  = 2'b00;
        if (w_is_subu || w_is_beq) begin
            w_cls_alu_op = 2'b01;
        end
        if (w_is_ori || w_is_lui) begin
            w_cls_alu_op  = 2'b10;
            w_cls_alu_src = 1'b1;
        end
        if (w_is_lui) begin
            w_cls_ext_op = 2'b10;
        end
        if (w_is_lw || w_is_sw) begin
            w_cls_alu_src = 1'b1;
            w_cls_ext_op  = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_FETCH;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (w_fetch_done) begin
                        r_state <= c_DCD;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_DCD:   r_state <= (w_is_j || w_is_jal || !w_legal) ? c_FETCH : c_EXE;
                c_EXE:   r_state <= w_is_beq ? c_FETCH : ((w_is_lw || w_is_sw) ? c_MEM : c_WB);
                c_MEM:   r_state <= w_is_lw ? c_WB : c_FETCH;
                c_WB:    r_state <= c_FETCH;
                default: begin
                    r_state <= c_FETCH;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Outputs are gated by rst so no enable can leak while reset is held
    always_comb begin
        pc_wr   = 1'b0;
        npc_sel = 2'b00;
        ir_wr   = 1'b0;
        gpr_wr  = 1'b0;
        reg_dst = 2'b00;
        wd_sel  = 2'b00;
        alu_src = 1'b0;
        ext_op  = 2'b00;
        alu_op  = 2'b00;
        dm_wr   = 1'b0;
        illegal = 1'b0;
        if (!rst) begin
            if (r_state inside {c_DCD, c_EXE, c_MEM, c_WB}) begin
                alu_op  = w_cls_alu_op;
                alu_src = w_cls_alu_src;
                ext_op  = w_cls_ext_op;
            end
            case (r_state)
                c_FETCH: begin
                    ir_wr = w_fetch_done;
                    pc_wr = w_fetch_done;
                end
                c_DCD: begin
                    if (w_is_j || w_is_jal) begin
                        pc_wr   = 1'b1;
                        npc_sel = 2'b10;
                    end
                    if (w_is_jal) begin
                        gpr_wr  = 1'b1;
                        reg_dst = 2'b10;
                        wd_sel  = 2'b10;
                    end
                    illegal = !w_legal;
                end
                c_EXE: begin
                    if (w_is_beq) begin
                        pc_wr   = zero;
                        npc_sel = 2'b01;
                    end
                end
                c_MEM:   dm_wr = w_is_sw;
                c_WB: begin
                    gpr_wr  = 1'b1;
                    reg_dst = w_is_rtype ? 2'b01 : 2'b00;
                    wd_sel  = w_is_lw ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;
    logic        w_retire;

    // An instruction retires on its final transition back to FETCH
    assign w_retire = ((r_state == c_DCD) && (w_is_j || w_is_jal)) ||
                      ((r_state == c_EXE) && w_is_beq) ||
                      ((r_state == c_MEM) && !w_is_lw) ||
                      (r_state == c_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl (IM_LAT=0 and IM_LAT=3
//               instances); counter checks build with MC_CTRL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst0, rst3, sel;
    logic [5:0] op, funct;
    logic       zero;

    logic       pc_wr0, ir_wr0, gpr_wr0, alu_src0, dm_wr0, illegal0;
    logic [1:0] npc_sel0, reg_dst0, wd_sel0, ext_op0, alu_op0;
    logic [2:0] state0;
    logic       pc_wr3, ir_wr3, gpr_wr3, alu_src3, dm_wr3, illegal3;
    logic [1:0] npc_sel3, reg_dst3, wd_sel3, ext_op3, alu_op3;
    logic [2:0] state3;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt0, instret_cnt0, cycle_cnt3, instret_cnt3;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int dm_sum, gw_sum, ill_sum, iw_sum;
    int ret_model = 0;
    int cyc_model = 0;
    logic [18:0] q[$];

    always #5 clk = ~clk;

    mc_ctrl #(.IM_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst0), .op(op), .funct(funct), .zero(zero),
        .pc_wr(pc_wr0), .npc_sel(npc_sel0), .ir_wr(ir_wr0), .gpr_wr(gpr_wr0),
        .reg_dst(reg_dst0), .wd_sel(wd_sel0), .alu_src(alu_src0), .ext_op(ext_op0),
        .alu_op(alu_op0), .dm_wr(dm_wr0), .illegal(illegal0), .state(state0)
`ifdef MC_CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt0), .instret_cnt(instret_cnt0)
`endif
    );

    mc_ctrl #(.IM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .op(op), .funct(funct), .zero(zero),
        .pc_wr(pc_wr3), .npc_sel(npc_sel3), .ir_wr(ir_wr3), .gpr_wr(gpr_wr3),
        .reg_dst(reg_dst3), .wd_sel(wd_sel3), .alu_src(alu_src3), .ext_op(ext_op3),
        .alu_op(alu_op3), .dm_wr(dm_wr3), .illegal(illegal3), .state(state3)
`ifdef MC_CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt3), .instret_cnt(instret_cnt3)
`endif
    );

    // {state, pc_wr, npc_sel, ir_wr, gpr_wr, reg_dst, wd_sel, alu_src, ext_op, alu_op, dm_wr, illegal}
    logic [18:0] v0, v3;
    assign v0 = {state0, pc_wr0, npc_sel0, ir_wr0, gpr_wr0, reg_dst0, wd_sel0,
                 alu_src0, ext_op0, alu_op0, dm_wr0, illegal0};
    assign v3 = {state3, pc_wr3, npc_sel3, ir_wr3, gpr_wr3, reg_dst3, wd_sel3,
                 alu_src3, ext_op3, alu_op3, dm_wr3, illegal3};

    function automatic logic [18:0] mk(input logic [2:0] st, input logic pw, input logic [1:0] ns,
                                       input logic iw, input logic gw, input logic [1:0] rd,
                                       input logic [1:0] wd, input logic as, input logic [1:0] eo,
                                       input logic [1:0] ao, input logic dw, input logic il);
        return {st, pw, ns, iw, gw, rd, wd, as, eo, ao, dw, il};
    endfunction

    // Expected per-cycle outputs of one whole instruction, from its class
    function automatic int build(input logic [5:0] o, input logic [5:0] f, input logic z, input int lat);
        int s0 = q.size();
        bit addu = (o == 6'h00) && (f == 6'h21);
        bit subu = (o == 6'h00) && (f == 6'h23);
        bit ori = (o == 6'h0d), lui = (o == 6'h0f), lw = (o == 6'h23), sw = (o == 6'h2b);
        bit beq = (o == 6'h04), j = (o == 6'h02), jal = (o == 6'h03);
        bit legal = addu || subu || ori || lui || lw || sw || beq || j || jal;
        logic [1:0] ao, eo;
        logic as;
        for (int i = 0; i < lat; i++) q.push_back(19'd0);
        q.push_back(mk(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        if (j || jal) begin
            q.push_back(mk(3'd1, 1'b1, 2'b10, 1'b0, jal, jal ? 2'b10 : 2'b00, jal ? 2'b10 : 2'b00,
                           1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
            ret_model++;
        end else if (!legal) begin
            q.push_back(mk(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1));
        end else begin
            ao = (subu || beq) ? 2'b01 : ((ori || lui) ? 2'b10 : 2'b00);
            as = ori || lui || lw || sw;
            eo = (lw || sw) ? 2'b01 : (lui ? 2'b10 : 2'b00);
            q.push_back(mk(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, as, eo, ao, 1'b0, 1'b0));
            if (beq) begin
                q.push_back(mk(3'd2, z, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, as, eo, ao, 1'b0, 1'b0));
            end else begin
                q.push_back(mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, as, eo, ao, 1'b0, 1'b0));
                if (lw || sw)
                    q.push_back(mk(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, as, eo, ao, sw, 1'b0));
                if (!sw)
                    q.push_back(mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, (addu || subu) ? 2'b01 : 2'b00,
                                   lw ? 2'b01 : 2'b00, as, eo, ao, 1'b0, 1'b0));
            end
            ret_model++;
        end
        return q.size() - s0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) if (!rst0) cyc_model++;

    always @(negedge clk) begin : p_cmp
        logic [18:0] e, a;
        a = sel ? v3 : v0;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs dut%0d t=%0t: got %05h expected %05h", sel ? 3 : 0, $time, a, e);
            end
            dm_sum  += int'(a[1]);
            gw_sum  += int'(a[11]);
            ill_sum += int'(a[0]);
            iw_sum  += int'(a[12]);
        end
        n_chk++;
        if ((sel ? v0 : v3) !== 19'd0) begin
            n_fail++;
            $display("FAIL idle_dut_quiet t=%0t: got %05h expected 00000", $time, sel ? v0 : v3);
        end
    end

    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int lat,
                       input int exp_len, input string nm);
        int n;
        op = o; funct = f; zero = z;
        dm_sum = 0; gw_sum = 0; ill_sum = 0; iw_sum = 0;
        n = build(o, f, z, lat);
        chk({nm, "_latency"}, n, exp_len);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int tmp;
        rst0 = 1'b1; rst3 = 1'b1; sel = 1'b0;
        op = 6'h03; funct = 6'h00; zero = 1'b1;
        @(negedge clk); #1;
        chk("reset_outputs", {13'd0, v0}, 32'd0);
        @(posedge clk); #1;
        rst0 = 1'b0;

        run(6'h0d, 6'h00, 1'b0, 0, 4, "ori");
        chk("ori_gpr_wr_cycles", gw_sum, 1);
        run(6'h23, 6'h00, 1'b0, 0, 5, "lw");
        chk("lw_gpr_wr_cycles", gw_sum, 1);
        run(6'h2b, 6'h00, 1'b0, 0, 4, "sw");
        chk("sw_dm_wr_cycles", dm_sum, 1);
        chk("sw_gpr_wr_cycles", gw_sum, 0);
        run(6'h04, 6'h00, 1'b1, 0, 3, "beq_taken");
        run(6'h04, 6'h00, 1'b0, 0, 3, "beq_not_taken");
        run(6'h03, 6'h00, 1'b0, 0, 2, "jal");
        run(6'h02, 6'h00, 1'b0, 0, 2, "j");
        run(6'h00, 6'h21, 1'b0, 0, 4, "addu");
        run(6'h00, 6'h23, 1'b1, 0, 4, "subu");
        run(6'h0f, 6'h00, 1'b0, 0, 4, "lui");
`ifdef MC_CTRL_PERF_CNT_EN
        tmp = int'(instret_cnt0);
`else
        tmp = 0;
`endif
        run(6'h3f, 6'h00, 1'b0, 0, 2, "illegal_op");
        chk("illegal_pulse_cycles", ill_sum, 1);
        run(6'h00, 6'h25, 1'b0, 0, 2, "illegal_funct");
        chk("illegal_funct_pulse_cycles", ill_sum, 1);
`ifdef MC_CTRL_PERF_CNT_EN
        chk("instret_unchanged_on_illegal", instret_cnt0, tmp);
        chk("instret_count", instret_cnt0, ret_model);
        chk("cycle_count", cycle_cnt0, cyc_model);
`endif

        rst0 = 1'b1; sel = 1'b1; rst3 = 1'b0;
        run(6'h00, 6'h21, 1'b0, 3, 7, "addu_lat3");
        chk("addu_lat3_ir_wr_cycles", iw_sum, 1);

        op = 6'h00; funct = 6'h21; zero = 1'b0;
        tmp = build(op, funct, zero, 3);
        void'(q.pop_back());
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        rst3 = 1'b1;
        #1;
        chk("rst_mid_exe_outputs", {13'd0, v3}, 32'd0);
        chk("rst_mid_exe_state", {29'd0, state3}, 32'd0);
        @(posedge clk); #1;
        chk("rst_held_no_partial_write", {13'd0, v3}, 32'd0);
        chk("expect_queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
